// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks destinations of in-flight long-latency ops,
// detects RAW/WAW/load-use/capacity hazards and drives stall and bubble controls.
module hazard_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int REG_W           = 5,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_W-1:0]    rs1_IFID,
    input  logic [REG_W-1:0]    rs2_IFID,
    input  logic                uses_rs1_IFID,
    input  logic                uses_rs2_IFID,
    input  logic [REG_W-1:0]    rd_IFID,
    input  logic                reg_wr_en_IFID,
    input  logic                long_op_IFID,
    input  logic [REG_W-1:0]    rd_IDEX,
    input  logic                mem_rd_en_IDEX,
    input  logic                long_done,
    input  logic [REG_W-1:0]    rd_done,
    input  logic                flush,
    output logic                stall_IF,
    output logic                stall_ID,
    output logic                bubble_IDEX,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [2:0]          outstanding_cnt,
    output logic                sb_error
);

    logic [NUM_REGS-1:0] r_pending;
    logic [2:0]          r_cnt;
    logic                r_err;

    logic                w_raw;
    logic                w_waw;
    logic                w_load_use;
    logic                w_full;
    logic                w_hazard;
    logic                w_issue;
    logic                w_dec;
    logic                w_err_set;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [2:0]          w_cnt_nxt;

    // Hazards see only registered state; a same-cycle retire does not release a stall.
    always_comb begin
        w_raw = (uses_rs1_IFID & r_pending[rs1_IFID] & (rs1_IFID != '0))
              | (uses_rs2_IFID & r_pending[rs2_IFID] & (rs2_IFID != '0));
        w_waw = reg_wr_en_IFID & (rd_IFID != '0) & r_pending[rd_IFID];
        w_load_use = mem_rd_en_IDEX & (rd_IDEX != '0)
                   & ((uses_rs1_IFID & (rs1_IFID == rd_IDEX))
                    | (uses_rs2_IFID & (rs2_IFID == rd_IDEX)));
        w_full   = long_op_IFID & (r_cnt == 3'(MAX_OUTSTANDING));
        w_hazard = w_raw | w_waw | w_load_use | w_full;
        w_issue  = long_op_IFID & ~w_hazard & ~flush;
        w_dec    = long_done & (r_cnt != '0);
        w_err_set = long_done & (((rd_done != '0) & ~r_pending[rd_done]) | (r_cnt == '0));
    end

    // Clear before set so an issue to the retiring register keeps its bit.
    always_comb begin
        w_pending_nxt = r_pending;
        if (long_done)
            w_pending_nxt[rd_done] = 1'b0;
        if (w_issue & reg_wr_en_IFID & (rd_IFID != '0))
            w_pending_nxt[rd_IFID] = 1'b1;
        w_pending_nxt[0] = 1'b0;

        case ({w_issue, w_dec})
            2'b10:   w_cnt_nxt = r_cnt + 3'd1;
            2'b01:   w_cnt_nxt = r_cnt - 3'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_cnt     <= w_cnt_nxt;
            r_err     <= r_err | w_err_set;
        end
    end

    // Flush discards the ID instruction, so it is bubbled rather than held.
    assign stall_IF        = w_hazard & ~flush;
    assign stall_ID        = w_hazard & ~flush;
    assign bubble_IDEX     = w_hazard | flush;
    assign pending_mask    = r_pending;
    assign outstanding_cnt = r_cnt;
    assign sb_error        = r_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: per-cycle stimulus with expected
// outputs queued alongside and compared mid-cycle.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_IFID, rs2_IFID, rd_IFID, rd_IDEX, rd_done;
    logic        uses_rs1_IFID, uses_rs2_IFID, reg_wr_en_IFID, long_op_IFID;
    logic        mem_rd_en_IDEX, long_done, flush;
    logic        stall_IF, stall_ID, bubble_IDEX, sb_error;
    logic [31:0] pending_mask;
    logic [2:0]  outstanding_cnt;

    hazard_scoreboard #(.NUM_REGS(32), .REG_W(5), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .reset(reset),
        .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
        .uses_rs1_IFID(uses_rs1_IFID), .uses_rs2_IFID(uses_rs2_IFID),
        .rd_IFID(rd_IFID), .reg_wr_en_IFID(reg_wr_en_IFID), .long_op_IFID(long_op_IFID),
        .rd_IDEX(rd_IDEX), .mem_rd_en_IDEX(mem_rd_en_IDEX),
        .long_done(long_done), .rd_done(rd_done), .flush(flush),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_IDEX(bubble_IDEX),
        .pending_mask(pending_mask), .outstanding_cnt(outstanding_cnt), .sb_error(sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, fl, u1; logic [4:0] rs1;
        logic       u2;          logic [4:0] rs2;
        logic       wr;          logic [4:0] rd;
        logic       lop, mrd;    logic [4:0] rdx;
        logic       ld;          logic [4:0] rdd;
    } stim_t;

    typedef struct {
        string       name;
        logic [38:0] v;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    passes = 0;

    function automatic stim_t S(input logic rst, fl, u1, input logic [4:0] rs1,
                                input logic u2, input logic [4:0] rs2,
                                input logic wr, input logic [4:0] rd, input logic lop,
                                input logic mrd, input logic [4:0] rdx,
                                input logic ld, input logic [4:0] rdd);
        stim_t s;
        s.rst = rst; s.fl = fl; s.u1 = u1; s.rs1 = rs1; s.u2 = u2; s.rs2 = rs2;
        s.wr = wr; s.rd = rd; s.lop = lop; s.mrd = mrd; s.rdx = rdx; s.ld = ld; s.rdd = rdd;
        return s;
    endfunction

    // Expected {stall_IF, stall_ID, bubble_IDEX, sb_error, outstanding_cnt, pending_mask}
    function automatic exp_t E(input string n, input logic st, bub, err,
                               input logic [2:0] cnt, input logic [31:0] m);
        exp_t e;
        e.name = n;
        e.v = {st, st, bub, err, cnt, m};
        return e;
    endfunction

    task automatic apply(input stim_t s);
        reset = s.rst; flush = s.fl;
        uses_rs1_IFID = s.u1; rs1_IFID = s.rs1; uses_rs2_IFID = s.u2; rs2_IFID = s.rs2;
        reg_wr_en_IFID = s.wr; rd_IFID = s.rd; long_op_IFID = s.lop;
        mem_rd_en_IDEX = s.mrd; rd_IDEX = s.rdx; long_done = s.ld; rd_done = s.rdd;
    endtask

    task automatic test_reset();
        exp_t e; logic [38:0] obs;
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("rst_state",0,0,0,0,32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #3;
            e = exp_q.pop_front();
            obs = {stall_IF, stall_ID, bubble_IDEX, sb_error, outstanding_cnt, pending_mask};
            checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t e; logic [38:0] obs;
        stim_q.push_back(S(0,0,1,5,0,0,1,8,0,1,5,0,0)); exp_q.push_back(E("lu_rs1_hit",1,1,0,0,32'h0));
        stim_q.push_back(S(0,0,1,5,0,0,1,8,0,0,5,0,0)); exp_q.push_back(E("lu_release",0,0,0,0,32'h0));
        stim_q.push_back(S(0,0,1,0,0,0,0,0,0,1,0,0,0)); exp_q.push_back(E("lu_x0",0,0,0,0,32'h0));
        stim_q.push_back(S(0,0,0,5,1,5,0,0,0,1,5,0,0)); exp_q.push_back(E("lu_rs2_hit",1,1,0,0,32'h0));
        stim_q.push_back(S(0,0,0,5,0,5,0,0,0,1,5,0,0)); exp_q.push_back(E("lu_unused",0,0,0,0,32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #3;
            e = exp_q.pop_front();
            obs = {stall_IF, stall_ID, bubble_IDEX, sb_error, outstanding_cnt, pending_mask};
            checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_long_raw();
        exp_t e; logic [38:0] obs;
        stim_q.push_back(S(0,0,0,0,0,0,1,7,1,0,0,0,0)); exp_q.push_back(E("raw_issue",0,0,0,0,32'h0));
        stim_q.push_back(S(0,0,0,0,1,7,0,0,0,0,0,0,0)); exp_q.push_back(E("raw_stall",1,1,0,1,32'h80));
        stim_q.push_back(S(0,0,0,0,1,7,0,0,0,0,0,1,7)); exp_q.push_back(E("raw_no_bypass",1,1,0,1,32'h80));
        stim_q.push_back(S(0,0,0,0,1,7,0,0,0,0,0,0,0)); exp_q.push_back(E("raw_release",0,0,0,0,32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #3;
            e = exp_q.pop_front();
            obs = {stall_IF, stall_ID, bubble_IDEX, sb_error, outstanding_cnt, pending_mask};
            checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_waw_capacity();
        exp_t e; logic [38:0] obs;
        stim_q.push_back(S(0,0,0,0,0,0,1,3,1,0,0,0,0)); exp_q.push_back(E("cap_issue3",0,0,0,0,32'h0));
        stim_q.push_back(S(0,0,0,0,0,0,1,4,1,0,0,0,0)); exp_q.push_back(E("cap_issue4",0,0,0,1,32'h8));
        stim_q.push_back(S(0,0,0,0,0,0,1,9,1,0,0,0,0)); exp_q.push_back(E("cap_full",1,1,0,2,32'h18));
        stim_q.push_back(S(0,0,0,0,0,0,1,3,0,0,0,0,0)); exp_q.push_back(E("cap_waw",1,1,0,2,32'h18));
        stim_q.push_back(S(0,0,0,0,0,0,1,9,1,0,0,1,3)); exp_q.push_back(E("cap_full_ret",1,1,0,2,32'h18));
        stim_q.push_back(S(0,0,0,0,0,0,1,9,1,0,0,0,0)); exp_q.push_back(E("cap_full_rel",0,0,0,1,32'h10));
        stim_q.push_back(S(0,0,0,0,0,0,1,3,0,0,0,0,0)); exp_q.push_back(E("cap_waw_rel",0,0,0,2,32'h210));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,1,4)); exp_q.push_back(E("cap_ret4",0,0,0,2,32'h210));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,1,9)); exp_q.push_back(E("cap_ret9",0,0,0,1,32'h200));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("cap_drained",0,0,0,0,32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #3;
            e = exp_q.pop_front();
            obs = {stall_IF, stall_ID, bubble_IDEX, sb_error, outstanding_cnt, pending_mask};
            checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; logic [38:0] obs;
        stim_q.push_back(S(0,0,0,0,0,0,1,3,1,0,0,0,0)); exp_q.push_back(E("sim_issue3",0,0,0,0,32'h0));
        stim_q.push_back(S(0,0,0,0,0,0,1,6,1,0,0,1,3)); exp_q.push_back(E("sim_both",0,0,0,1,32'h8));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,1,6)); exp_q.push_back(E("sim_after",0,0,0,1,32'h40));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("sim_drained",0,0,0,0,32'h0));
        stim_q.push_back(S(0,0,0,0,0,0,1,0,1,0,0,0,0)); exp_q.push_back(E("x0_issue",0,0,0,0,32'h0));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,1,0)); exp_q.push_back(E("x0_counted",0,0,0,1,32'h0));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("x0_retired",0,0,0,0,32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #3;
            e = exp_q.pop_front();
            obs = {stall_IF, stall_ID, bubble_IDEX, sb_error, outstanding_cnt, pending_mask};
            checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        exp_t e; logic [38:0] obs;
        stim_q.push_back(S(0,0,0,0,0,0,1,7,1,0,0,0,0)); exp_q.push_back(E("fl_issue7",0,0,0,0,32'h0));
        stim_q.push_back(S(0,1,1,7,0,0,1,10,1,0,0,0,0)); exp_q.push_back(E("fl_raw",0,1,0,1,32'h80));
        stim_q.push_back(S(0,1,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("fl_no_issue",0,1,0,1,32'h80));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,1,7)); exp_q.push_back(E("fl_ret7",0,0,0,1,32'h80));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("fl_drained",0,0,0,0,32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #3;
            e = exp_q.pop_front();
            obs = {stall_IF, stall_ID, bubble_IDEX, sb_error, outstanding_cnt, pending_mask};
            checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_error();
        exp_t e; logic [38:0] obs;
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,1,12)); exp_q.push_back(E("err_pre",0,0,0,0,32'h0));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("err_empty",0,0,1,0,32'h0));
        stim_q.push_back(S(1,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("err_sticky",0,0,1,0,32'h0));
        stim_q.push_back(S(0,0,0,0,0,0,1,5,1,0,0,0,0)); exp_q.push_back(E("err_cleared",0,0,0,0,32'h0));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,1,12)); exp_q.push_back(E("err_pre2",0,0,0,1,32'h20));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("err_notpend",0,0,1,0,32'h20));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("err_stays",0,0,1,0,32'h20));
        stim_q.push_back(S(1,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("err_rst_in",0,0,1,0,32'h20));
        stim_q.push_back(S(0,0,0,0,0,0,0,0,0,0,0,1,0)); exp_q.push_back(E("err_pre3",0,0,0,0,32'h0));
        stim_q.push_back(S(1,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("err_cnt0",0,0,1,0,32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #3;
            e = exp_q.pop_front();
            obs = {stall_IF, stall_ID, bubble_IDEX, sb_error, outstanding_cnt, pending_mask};
            checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e; logic [38:0] obs;
        stim_q.push_back(S(0,0,0,0,0,0,1,3,1,0,0,0,0)); exp_q.push_back(E("rm_issue3",0,0,0,0,32'h0));
        stim_q.push_back(S(0,0,0,0,0,0,1,4,1,0,0,0,0)); exp_q.push_back(E("rm_issue4",0,0,0,1,32'h8));
        stim_q.push_back(S(1,0,0,0,0,0,0,0,0,0,0,0,0)); exp_q.push_back(E("rm_two_out",0,0,0,2,32'h18));
        stim_q.push_back(S(0,0,0,0,1,3,0,0,0,0,0,0,0)); exp_q.push_back(E("rm_cleared",0,0,0,0,32'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front()); #3;
            e = exp_q.pop_front();
            obs = {stall_IF, stall_ID, bubble_IDEX, sb_error, outstanding_cnt, pending_mask};
            checks++;
            if (obs !== e.v) $display("FAIL %s: got %h expected %h", e.name, obs, e.v); else passes++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        apply(S(1,0,0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_long_raw();
        test_waw_capacity();
        test_back_to_back();
        test_flush();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side hazard tracking for the ID stage of the pipelined core.
- Records destination registers of in-flight long-latency operations (multi-cycle MUL/DIV/MMM unit) and detects load-use hazards.
- Stalls IF/ID and injects an ID/EX bubble when a consumer in ID cannot be satisfied by EX-stage forwarding.
- Releases the stall when the producer retires.

Parameters:
NUM_REGS, 32, architectural register count; x0 is never tracked
REG_W, 5, register index width
MAX_OUTSTANDING, 2, maximum long-latency ops in flight (1..7)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
rs1_IFID  input  REG_W  rs1 field of instruction in ID
rs2_IFID  input  REG_W  rs2 field of instruction in ID
uses_rs1_IFID  input  1  ID instruction reads rs1
uses_rs2_IFID  input  1  ID instruction reads rs2
rd_IFID  input  REG_W  rd field of instruction in ID
reg_wr_en_IFID  input  1  ID instruction writes rd
long_op_IFID  input  1  ID instruction targets the long-latency unit
rd_IDEX  input  REG_W  rd of instruction in EX
mem_rd_en_IDEX  input  1  instruction in EX is a load
long_done  input  1  long unit retires a result this cycle
rd_done  input  REG_W  destination of the retiring long op
flush  input  1  branch/jump redirect; kills the ID instruction
stall_IF  output  1  hold PC
stall_ID  output  1  hold IF/ID register
bubble_IDEX  output  1  load NOP into ID/EX
pending_mask  output  NUM_REGS  registered pending bit per register
outstanding_cnt  output  3  long ops currently in flight
sb_error  output  1  sticky: retire of a non-pending register

Behaviour:
- Reset (synchronous, active-high): pending_mask=0, outstanding_cnt=0, sb_error=0. The stall outputs are combinational and follow the equations below.
- Hazard terms are combinational on the current inputs and the registered state. There is no bypass of same-cycle long_done into the stall logic.
  - raw = (uses_rs1_IFID & pending_mask[rs1_IFID] & rs1_IFID!=0) | (uses_rs2_IFID & pending_mask[rs2_IFID] & rs2_IFID!=0)
  - waw = reg_wr_en_IFID & rd_IFID!=0 & pending_mask[rd_IFID]
  - load_use = mem_rd_en_IDEX & rd_IDEX!=0 & ((uses_rs1_IFID & rs1_IFID==rd_IDEX) | (uses_rs2_IFID & rs2_IFID==rd_IDEX))
  - full = long_op_IFID & (outstanding_cnt == MAX_OUTSTANDING)
  - hazard = raw | waw | load_use | full
- Output equations:
  - stall_IF = stall_ID = hazard & ~flush
  - bubble_IDEX = hazard | flush
  - flush has priority: the ID instruction is discarded, not held.
- Issue: issue = long_op_IFID & ~hazard & ~flush. On issue, at the next edge:
  - pending_mask[rd_IFID] <= 1 if reg_wr_en_IFID & rd_IFID!=0
  - outstanding_cnt increments, including when rd is x0.
- Retire: on long_done, at the next edge:
  - pending_mask[rd_done] <= 0.
  - outstanding_cnt decrements if outstanding_cnt != 0.
  - If rd_done!=0 and pending_mask[rd_done]==0, set sb_error. The mask and the decrement are still applied as above.
  - If outstanding_cnt==0, set sb_error and do not decrement.
- Simultaneous issue and retire in one cycle:
  - outstanding_cnt is unchanged.
  - Both mask updates apply.
  - The same register in both updates cannot occur, because waw blocks the issue. If it occurs anyway, set wins.
- A stalled consumer is released the cycle after long_done for its register: a 1-cycle retire-to-release latency.
- Load-use stall lasts exactly 1 cycle, because the bubble moves the load to MEM. EX/MEM and WB forwarding then supplies the data.
- Reset mid-operation clears all tracking, even with outstanding ops in flight. The long unit is reset concurrently.
- pending_mask bit 0 is always 0.

Test Plan:
- Load-use: lw x5 in EX (mem_rd_en_IDEX=1, rd_IDEX=5); ID has add using rs1=5 -> stall_IF=stall_ID=bubble_IDEX=1 for 1 cycle, then 0. Repeat with rs1=0 and rd_IDEX=0 -> no stall.
- Long RAW: issue long op rd=7 -> pending_mask=0x80, outstanding_cnt=1. ID reads rs2=7 -> stall holds. long_done with rd_done=7 at cycle N -> stall deasserts at N+1 and pending_mask=0.
- WAW and capacity, MAX_OUTSTANDING=2:
  - Issue rd=3, then rd=4 -> outstanding_cnt=2.
  - Third long op (rd=9) stalls (full).
  - A non-long op writing x3 stalls (waw).
  - Retire rd=3 -> both stalls release next cycle.
- Simultaneous issue and retire: outstanding_cnt=1 with x3 pending; issue rd=6 while long_done rd_done=3 -> outstanding_cnt stays 1, pending_mask=0x40.
- Flush during hazard: raw active and flush=1 -> stall_IF=stall_ID=0, bubble_IDEX=1, no issue, mask unchanged.
- Error and reset:
  - long_done with rd_done=12 not pending -> sb_error=1 and stays 1.
  - long_done with outstanding_cnt=0 -> sb_error=1, counter stays 0.
  - reset asserted with two ops outstanding -> next cycle pending_mask=0, outstanding_cnt=0, sb_error=0.
